// File: rtl/freq_meter.sv
// freq_meter: counts rising edges and high time of an asynchronous input over
// a fixed gate window of GATE_CYCLES clk cycles, then latches the results with
// a one-cycle valid strobe. The next window starts on the cycle after the last
// one, so there is no gap between windows.
module freq_meter #(
    parameter int unsigned CLK_FREQ    = 12000000,
    parameter int unsigned GATE_CYCLES = 12000000,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned GATE_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  freq_cnt,
    output logic [GATE_W-1:0] high_cnt,
    output logic              meas_ovf,
    output logic              meas_valid
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // Reject parameter sets that would make the meter meaningless.
    if (CLK_FREQ == 0 || GATE_CYCLES == 0 || CNT_W == 0) begin : g_param_check
        $error("freq_meter: CLK_FREQ, GATE_CYCLES and CNT_W must be non-zero");
    end

    logic              s1, s2, s3;
    logic [1:0]        arm_cnt;
    logic              armed;
    logic              rise;
    logic              hi;
    logic              edge_full;
    logic              sat_now;
    logic              win_last;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  edge_next;
    logic [GATE_W-1:0] gate_cnt;
    logic [GATE_W-1:0] high_cnt_r;
    logic [GATE_W-1:0] high_next;
    logic              ovf_r;

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Arm counter: ignores the synchroniser for 3 cycles after reset so a
    // level already high at reset release is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    // Edge/level qualification and next-value arithmetic for the counters.
    always_comb begin
        armed     = (arm_cnt == 2'd3);
        rise      = s2 & ~s3 & armed;
        hi        = s2 & armed;
        edge_full = &edge_cnt;
        sat_now   = rise & edge_full;
        edge_next = edge_cnt + CNT_W'(rise & ~edge_full);
        high_next = high_cnt_r + GATE_W'(hi);
        win_last  = en && (gate_cnt == GATE_LAST);
    end

    // Window counters: cleared while idle, restart from 0 right after close.
    always_ff @(posedge clk) begin
        if (rst || !en || win_last) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            high_cnt_r <= '0;
            ovf_r      <= 1'b0;
        end else begin
            gate_cnt   <= gate_cnt + GATE_W'(1);
            edge_cnt   <= edge_next;
            high_cnt_r <= high_next;
            ovf_r      <= ovf_r | sat_now;
        end
    end

    // Result registers: latch the closing cycle's totals and pulse valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_cnt   <= '0;
            high_cnt   <= '0;
            meas_ovf   <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= win_last;
            if (win_last) begin
                freq_cnt <= edge_next;
                high_cnt <= high_next;
                meas_ovf <= ovf_r | sat_now;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of freq_meter with a 100-cycle gate window;
// a second instance with a 3-bit edge counter exercises saturation.
module tb_freq_meter;

    logic        clk;
    logic        rst, en, sig_in;
    logic        rst3, en3, sig3;
    logic [23:0] freq_cnt, high_cnt;
    logic        meas_ovf, meas_valid;
    logic [2:0]  freq3;
    logic [23:0] high3;
    logic        ovf3, v3;

    int n_checks = 0;
    int n_pass   = 0;
    bit sq_on    = 0;
    bit sq3_on   = 0;
    int ph       = 0;
    int ph3      = 0;

    freq_meter #(
        .CLK_FREQ   (12000000),
        .GATE_CYCLES(100),
        .CNT_W      (24),
        .GATE_W     (24)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .freq_cnt  (freq_cnt),
        .high_cnt  (high_cnt),
        .meas_ovf  (meas_ovf),
        .meas_valid(meas_valid)
    );

    freq_meter #(
        .CLK_FREQ   (12000000),
        .GATE_CYCLES(100),
        .CNT_W      (3),
        .GATE_W     (24)
    ) u_dut3 (
        .clk       (clk),
        .rst       (rst3),
        .en        (en3),
        .sig_in    (sig3),
        .freq_cnt  (freq3),
        .high_cnt  (high3),
        .meas_ovf  (ovf3),
        .meas_valid(v3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sq_on) begin
            ph++;
            sig_in = (ph % 10) >= 5;
        end
        if (sq3_on) begin
            ph3++;
            sig3 = (ph3 % 8) >= 4;
        end
    endtask

    task automatic wait_valid(input bit which, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(which ? v3 : meas_valid) && n < limit);
    endtask

    initial begin
        int n;
        int vc;
        rst = 1; en = 0; sig_in = 0;
        rst3 = 1; en3 = 0; sig3 = 0;
        repeat (4) tick();
        check("rst_freq",  freq_cnt,   0);
        check("rst_high",  high_cnt,   0);
        check("rst_ovf",   meas_ovf,   0);
        check("rst_valid", meas_valid, 0);

        // Square wave, period 10, 5 high / 5 low.
        rst = 0; en = 1; ph = 0; sig_in = 0; sq_on = 1;
        wait_valid(0, 300, n);
        check("t1_lat1", n, 100);
        for (int w = 2; w <= 3; w++) begin
            wait_valid(0, 300, n);
            check($sformatf("t1_lat%0d", w), n, 100);
            check($sformatf("t1_freq%0d", w), freq_cnt, 10);
            check($sformatf("t1_high%0d", w), high_cnt, 50);
            check($sformatf("t1_ovf%0d", w),  meas_ovf, 0);
        end

        // Abort mid-window by dropping en for 20 cycles.
        repeat (50) tick();
        en = 0;
        vc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (meas_valid) vc++;
        end
        check("t4_no_valid", vc, 0);
        check("t4_freq_hold", freq_cnt, 10);
        en = 1;
        wait_valid(0, 300, n);
        check("t4_lat", n, 100);
        check("t4_freq", freq_cnt, 10);
        check("t4_high", high_cnt, 50);

        // Reset pulse at cycle 60, then an edge on the window's last cycle.
        repeat (60) tick();
        rst = 1; sq_on = 0; sig_in = 0;
        tick();
        check("t5_rst_freq",  freq_cnt,   0);
        check("t5_rst_high",  high_cnt,   0);
        check("t5_rst_valid", meas_valid, 0);
        rst = 0;
        repeat (97) tick();
        sig_in = 1;
        wait_valid(0, 300, n);
        check("t5_lat", n, 3);
        check("t5_freq_last", freq_cnt, 1);
        check("t5_high_last", high_cnt, 1);
        wait_valid(0, 300, n);
        check("t5_lat2", n, 100);
        check("t5_freq2", freq_cnt, 0);
        check("t5_high2", high_cnt, 100);

        // Input held high through and after reset.
        rst = 1;
        repeat (3) tick();
        rst = 0;
        wait_valid(0, 300, n);
        check("t2_lat1",  n, 100);
        check("t2_freq1", freq_cnt, 0);
        check("t2_high1", high_cnt, 97);
        wait_valid(0, 300, n);
        check("t2_freq2", freq_cnt, 0);
        check("t2_high2", high_cnt, 100);

        // 3-bit edge counter: saturation and overflow flag, then a quiet window.
        rst3 = 0; en3 = 1; ph3 = 0; sig3 = 0; sq3_on = 1;
        repeat (90) tick();
        sq3_on = 0; sig3 = 0;
        wait_valid(1, 300, n);
        check("t3_lat1",  n, 10);
        check("t3_freq1", freq3, 7);
        check("t3_ovf1",  ovf3, 1);
        check("t3_high1", high3, 44);
        wait_valid(1, 300, n);
        check("t3_lat2",  n, 100);
        check("t3_freq2", freq3, 0);
        check("t3_ovf2",  ovf3, 0);
        check("t3_high2", high3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
